// File: rtl/arith_unit_sched_29_if.sv
// Request/response channels between the client blocks and the arith-unit scheduler.
// Bit n (or slice n) of each request field belongs to requester n.
interface arith_unit_sched_29_if #(
    parameter int unsigned M = 32
);
    logic [1:0]     req_valid;
    logic [2*M-1:0] req_A;
    logic [2*M-1:0] req_B;
    logic [7:0]     req_op;
    logic [1:0]     req_ready;

    logic           rsp_valid;
    logic           rsp_id;
    logic [M-1:0]   rsp_result;
    logic [3:0]     rsp_status;
    logic           rsp_ready;

    // Client side
    modport master (
        output req_valid, req_A, req_B, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_status
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_A, req_B, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_status
    );
endinterface

// File: rtl/arith_unit_sched_29.sv
// Two-requester round-robin scheduler for the shared synchronous arithmetic unit.
// One operation in flight: grant, hold operands for SETTLE cycles, capture, respond.
module arith_unit_sched_29 #(
    parameter int unsigned M      = 32,
    parameter int unsigned SETTLE = 3
) (
    input  logic                 clk,
    input  logic                 i_reset,
    arith_unit_sched_29_if.slave bus,
    output logic [M-1:0]         o_au_A,
    output logic [M-1:0]         o_au_B,
    output logic [3:0]           o_au_op,
    input  logic [M-1:0]         i_au_result,
    input  logic [3:0]           i_au_status,
    output logic                 o_busy,
    output logic [7:0]           o_err_count
);
    localparam int unsigned CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e        state;
    logic          ptr;
    logic          id_q;
    logic [CW-1:0] cnt;
    logic [1:0]    grant;
    logic          gid;

    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic [M-1:0]  rsp_result_q;
    logic [3:0]    rsp_status_q;

    // Round-robin grant: pointer requester first, then the other; nothing while in reset.
    always_comb begin
        grant = 2'b00;
        gid   = ptr;
        if (i_reset && state == StIdle) begin
            if (bus.req_valid[ptr]) begin
                grant[ptr] = 1'b1;
                gid        = ptr;
            end else if (bus.req_valid[~ptr]) begin
                grant[~ptr] = 1'b1;
                gid         = ~ptr;
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_status = rsp_status_q;
    assign o_busy         = (state != StIdle);

    // Scheduler FSM with registered operand, response and error-count outputs.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= StIdle;
            ptr          <= 1'b0;
            id_q         <= 1'b0;
            cnt          <= '0;
            o_au_A       <= '0;
            o_au_B       <= '0;
            o_au_op      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_status_q <= '0;
            o_err_count  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (|grant) begin
                        o_au_A  <= gid ? bus.req_A[2*M-1:M] : bus.req_A[M-1:0];
                        o_au_B  <= gid ? bus.req_B[2*M-1:M] : bus.req_B[M-1:0];
                        o_au_op <= gid ? bus.req_op[7:4]    : bus.req_op[3:0];
                        id_q    <= gid;
                        ptr     <= ~gid;
                        cnt     <= CW'(1);
                        state   <= StIssue;
                    end
                end
                StIssue: begin
                    // Result settles one cycle after issue, status one cycle after result.
                    if (cnt == CW'(SETTLE)) begin
                        rsp_result_q <= i_au_result;
                        rsp_status_q <= i_au_status;
                        rsp_id_q     <= id_q;
                        rsp_valid_q  <= 1'b1;
                        state        <= StResp;
                        if (i_au_status[3] && o_err_count != 8'hFF) begin
                            o_err_count <= o_err_count + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule
